// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered select mux (mux_pipe_n).
package mux_pkg;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

    // Select width for a channel count; never below 1 so a 2-way mux still has a select bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_reg.sv
// One-entry holding register (data plus valid flag) used behind the mux output
// register when MUX_PIPE_SKID_EN is defined; absent from the default build.
`ifdef MUX_PIPE_SKID_EN
module skid_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mux_pipe_n.sv
// N-way, W-bit registered select mux with valid/ready handshake and a saturating
// out-of-range select counter. Define MUX_PIPE_SKID_EN to add a one-entry skid register.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int SEL_W = clog2(N)
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Handshake: a transfer happens on a side exactly when valid && ready are both high
    // at a rising edge; a producer holds its payload while valid is high and ready is low.
    logic [W-1:0] sel_word;
    logic         sel_bad;
    logic         accept;

    always_comb begin
        sel_word = '0;
        sel_bad  = (32'(in_sel) >= N);
        for (int k = 0; k < N; k++) begin
            if (32'(in_sel) == k) sel_word = in_data[k*W +: W];
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_cnt <= '0;
        end else if (accept && sel_bad && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef MUX_PIPE_SKID_EN
    logic         out_free;
    logic         skid_valid;
    logic [W:0]   skid_q;
    logic         skid_load;
    logic         skid_unload;

    // in_ready comes only from the skid flag, breaking the combinational path from out_ready.
    assign in_ready    = !skid_valid;
    assign out_free    = !out_valid || out_ready;
    assign skid_load   = accept && !out_free;
    assign skid_unload = skid_valid && out_free;

    skid_reg #(
        .WIDTH(W + 1)
    ) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .load  (skid_load),
        .unload(skid_unload),
        .d     ({sel_bad, sel_word}),
        .valid (skid_valid),
        .q     (skid_q)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_err   <= skid_q[W];
                out_data  <= skid_q[W-1:0];
            end else if (accept) begin
                out_valid <= 1'b1;
                out_err   <= sel_bad;
                out_data  <= sel_word;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_err   <= sel_bad;
            out_data  <= sel_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: an 8-way and a 5-way instance share handshake stimulus and are
// compared every cycle against a capacity-based queue model of the handshake.
module tb_mux_pipe_n;

    localparam int W = 32;
`ifdef MUX_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic           clk = 1'b0;
    logic           clrn = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [2:0]     in_sel = '0;
    logic [8*W-1:0] in_data = '0;

    logic           rdy8, ov8, oe8;
    logic [W-1:0]   od8;
    logic [7:0]     ec8;
    logic           rdy5, ov5, oe5;
    logic [W-1:0]   od5;
    logic [7:0]     ec5;

    // Model state: held words in order, packed as {err5, data5, data8}.
    logic [2*W:0]   exp_q[$];
    int             exp_err = 0;
    int             n_vec = 0;
    int             n_cmp = 0;
    int             n_fail = 0;
    int             n_dut_acc = 0;

    always #5 clk = ~clk;

    mux_pipe_n #(.N(8), .W(W)) dut8 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .out_err(oe8), .err_cnt(ec8)
    );

    mux_pipe_n #(.N(5), .W(W)) dut5 (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(rdy5),
        .in_data(in_data[5*W-1:0]), .in_sel(in_sel), .out_valid(ov5), .out_ready(out_ready),
        .out_data(od5), .out_err(oe5), .err_cnt(ec5)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [8*W-1:0] make_data(input logic [W-1:0] base);
        logic [8*W-1:0] d;
        for (int k = 0; k < 8; k++) d[k*W +: W] = base + W'(k);
        return d;
    endfunction

    function automatic logic [8*W-1:0] rand_data();
        logic [8*W-1:0] d;
        for (int k = 0; k < 8; k++) d[k*W +: W] = $urandom;
        return d;
    endfunction

    function automatic void check_outputs();
        logic [2*W:0] h;
        chk("out_valid8", 32'(ov8), 32'(exp_q.size() > 0));
        chk("out_valid5", 32'(ov5), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("out_data8", od8, h[W-1:0]);
            chk("out_err8", 32'(oe8), 32'd0);
            chk("out_data5", od5, h[2*W-1:W]);
            chk("out_err5", 32'(oe5), 32'(h[2*W]));
        end
        chk("err_cnt8", 32'(ec8), 32'd0);
        chk("err_cnt5", 32'(ec5), 32'(exp_err));
    endfunction

    // One cycle: drive at the falling edge, check ready, advance the model at the
    // rising edge, then check the registered outputs at the next falling edge.
    task automatic step(input logic v, input logic r, input logic [2:0] s, input logic [8*W-1:0] d);
        logic         exp_rdy;
        logic         acc;
        logic [W-1:0] w8;
        logic [W-1:0] w5;
        logic         e5;
        in_valid  = v;
        out_ready = r;
        in_sel    = s;
        in_data   = d;
        n_vec++;
        #1;
`ifdef MUX_PIPE_SKID_EN
        exp_rdy = (exp_q.size() < CAP);
`else
        exp_rdy = (exp_q.size() == 0) || r;
`endif
        chk("in_ready8", 32'(rdy8), 32'(exp_rdy));
        chk("in_ready5", 32'(rdy5), 32'(exp_rdy));
        if (v && rdy8) n_dut_acc++;
        acc = v && exp_rdy;
        w8  = d[s*W +: W];
        e5  = (s >= 3'd5);
        w5  = e5 ? '0 : d[s*W +: W];
        @(posedge clk);
        if ((exp_q.size() > 0) && r) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back({e5, w5, w8});
            if (e5 && exp_err < 255) exp_err++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_out_valid5", 32'(ov5), 32'd0);
        chk("rst_err_cnt5", 32'(ec5), 32'd0);
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("rst_in_ready8", 32'(rdy8), 32'd1);
        chk("rst_in_ready5", 32'(rdy5), 32'd1);
        chk("rst_out_data8", od8, 32'd0);
        chk("rst_out_err5", 32'(oe5), 32'd0);
        chk("rst_err_cnt8", 32'(ec8), 32'd0);
    endtask

    initial begin
        do_reset();

        // Basic select at full throughput.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 3'(k), make_data(32'hA0000000));
            chk("basic_lit8", od8, 32'hA0000000 + 32'(k));
        end
        step(1'b0, 1'b1, 3'd0, '0);

        // Out-of-range select on the 5-way instance, then saturation.
        do_reset();
        step(1'b1, 1'b1, 3'd6, make_data(32'hA0000000));
        chk("oor_data5", od5, 32'd0);
        chk("oor_err5", 32'(oe5), 32'd1);
        chk("oor_cnt5", 32'(ec5), 32'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 3'(5 + (i % 3)), rand_data());
        chk("sat_cnt5", 32'(ec5), 32'd255);
        step(1'b0, 1'b1, 3'd0, '0);

        // Backpressure for 4 cycles, then drain.
        n_dut_acc = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'(i), make_data(32'hB0000000));
        chk("bp_accepts", 32'(n_dut_acc), 32'(CAP));
        chk("bp_hold8", od8, 32'hB0000000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, rand_data());
        chk("bp_drained8", 32'(ov8), 32'd0);

        // Simultaneous accept and completion on a full register.
        step(1'b1, 1'b0, 3'd2, make_data(32'hC0000000));
        step(1'b1, 1'b1, 3'd4, make_data(32'hC1000000));
        chk("simul_valid8", 32'(ov8), 32'd1);
        chk("simul_data8", od8, 32'hC1000004);
        step(1'b0, 1'b1, 3'd0, '0);

        // Reset while words are held.
        step(1'b1, 1'b0, 3'd6, rand_data());
        step(1'b1, 1'b0, 3'd1, rand_data());
        do_reset();
        step(1'b0, 1'b1, 3'd0, rand_data());

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), rand_data());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised N-way, W-bit registered select mux with valid/ready handshake, successor to the fixed 4×32 combinational operand mux used in the pipeline datapath. Picks one of `N` input words per accepted transfer, registers the result, flags out-of-range selects, and counts them. It sits between the forwarding/operand-select logic and the next pipeline stage, so stalls propagate through `in_ready`/`out_ready` instead of global enables.

## Interface
- `N`, default 8: number of input channels, at least 2 and not required to be a power of 2.
- `W`, default 32: data width per channel.
- `SEL_W`, default `clog2(N)` (minimum 1): select width.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `clrn`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: the input transfer is offered.
- `in_ready`, output, 1: the block can accept the offered transfer.
- `in_data`, input, N*W: flattened channels. Channel k occupies bits [k*W +: W].
- `in_sel`, input, SEL_W: channel index, sampled together with `in_data`.
- `out_valid`, output, 1: output word held.
- `out_ready`, input, 1: downstream accepts the output.
- `out_data`, output, W: selected word.
- `out_err`, output, 1: the held word came from an out-of-range select.
- `err_cnt`, output, 8: saturating count of accepted out-of-range selects.

## Operation
- An input transfer is accepted on a cycle with `in_valid && in_ready`.
- An output transfer completes on a cycle with `out_valid && out_ready`.
- On accept with `in_sel < N`: store the word from channel `in_sel` and set `err` to 0.
- On accept with `in_sel >= N`: store an all-zero word, set `err` to 1, and increment `err_cnt`.
- `err_cnt` saturates at 255. It clears only on reset.
- `out_data` and `out_err` stay stable while `out_valid && !out_ready`.
- `in_data` and `in_sel` are ignored when the block does not accept.
- Transfers are never dropped or duplicated, and output order equals accept order.
- Reset values: `out_valid` 0, `out_data` 0, `out_err` 0, `err_cnt` 0.
- Reset may assert at any time. It discards held words at once, with no partial output. After `clrn` rises, `in_ready` is 1.

## Timing
- Latency is 1 cycle: a word accepted at edge t has `out_valid` high after edge t.
- Full throughput: one transfer per cycle while `out_ready` stays high.
- `in_ready` rule without the skid option: `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
- Simultaneous accept and output completion on a full register: the new word replaces the old one in the same edge and `out_valid` stays 1.
- Output completion with no accept: `out_valid` goes to 0.

## Configuration
- `MUX_PIPE_SKID_EN` defined: adds a one-entry skid register behind the output register.
  - `in_ready` is driven from a register and equals "skid empty", with no combinational path from `out_ready`.
  - When `out_ready` drops while a word is in flight, the incoming accepted word goes to the skid register. `in_ready` falls on the next cycle.
  - On the next output completion, the skid word moves to the output register.
  - Latency stays 1 cycle. Reset clears the skid register and its valid flag.
- `MUX_PIPE_SKID_EN` undefined: a single register, `in_ready` follows the Timing rule, and no skid state exists.

## Structure
- Shared package `mux_pkg` holds:
  - the `clog2` function,
  - `ERR_CNT_W = 8`,
  - `ERR_CNT_MAX = 8'hFF`.
- Sub-module `skid_reg`, parametrised width `W+1` (data plus err bit), exists only under `MUX_PIPE_SKID_EN`.
- Select decode is a plain loop over `N`, with no `case` on a fixed width. Unmatched selects produce zero.

## Test plan
- Reset and basic select: N=8, W=32. After `clrn` rises, all outputs are 0 and `in_ready` is 1. Channel k holds `32'hA0000000 + k`. Select 0..7 one per cycle with `out_ready` 1 → `out_data` A0000000..A0000007, each 1 cycle after accept, `out_err` 0.
- Out-of-range select: N=5, in_sel=6 → `out_data` 0, `out_err` 1, `err_cnt` 1. Then 300 bad selects → `err_cnt` holds 255.
- Backpressure: hold `out_ready` 0 for 4 cycles with `in_valid` 1.
  - Output stays stable.
  - Without skid: `in_ready` is 0 after the first word.
  - With skid: two words are accepted, then `in_ready` is 0.
  - After release, words come out in order with none lost.
- Simultaneous accept and completion: full register, `out_ready` 1, new word accepted in the same cycle → `out_valid` stays 1 and the next cycle shows the new word.
- Reset mid-flight: `clrn` low while `out_valid` is 1 (and the skid register is full, under the option) → `out_valid` 0 and `err_cnt` 0 immediately, with no stale word after release.
- Random soak: 10,000 cycles of random `in_valid`, `out_ready` and `in_sel` (including out-of-range) against a scoreboard. Passes when the output sequence equals the reference select sequence in both configurations.
